// File: rtl/mult_seq_32.sv
// Iterative shift-add multiplier, 32x32 -> 64, signed or unsigned.
// One bit per RUN cycle, then a sign-fix pass before the result is published.
module mult_seq_32 #(
  parameter int N = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         SIGNED,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         BUSY,
  output logic         DONE,
  output logic [N-1:0] HI,
  output logic [N-1:0] LO
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    FIN
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q, neg_d;
  logic           done_q, done_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;

  logic           accept;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic [2*N-1:0] addend;

  // The DONE cycle acts as a cooldown so held START leaves one idle cycle.
  assign accept = (state_q == IDLE) && START && !done_q;

  assign a_mag  = (SIGNED && A[N-1]) ? (N'(0) - A) : A;
  assign b_mag  = (SIGNED && B[N-1]) ? (N'(0) - B) : B;
  assign addend = {{N{1'b0}}, mcand_q} << cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (cnt_q == CW'(N - 1)) state_d = FIX;
      FIX:  state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = SIGNED & (A[N-1] ^ B[N-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = acc_q + addend;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
      end
      FIX: begin
        if (neg_q) acc_d = (2*N)'(0) - acc_q;
      end
      FIN: begin
        done_d = 1'b1;
        hi_d   = acc_q[2*N-1:N];
        lo_d   = acc_q[N-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    BUSY = (state_q != IDLE);
    DONE = done_q;
    HI   = hi_q;
    LO   = lo_q;
  end

endmodule

// File: tb/tb_mult_seq_32.sv
// Bench for mult_seq_32: vector table, random model checks,
// handshake sequences and mid-operation reset.
module tb_mult_seq_32;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        SIGNED = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        BUSY;
  logic        DONE;
  logic [31:0] HI;
  logic [31:0] LO;

  mult_seq_32 dut (
    .CLK(CLK), .RST(RST), .START(START), .SIGNED(SIGNED),
    .A(A), .B(B), .BUSY(BUSY), .DONE(DONE), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } sb_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  sb_t         sb[$];
  int          done_cyc[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          n_acc = 0;
  int          n_done = 0;
  logic        chk_busy = 1'b0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Scoreboard: predict acceptance from pre-edge status, pop on DONE.
  always @(negedge CLK) begin
    sb_t e;
    if (chk_busy) begin
      check("busy_after_accept", 64'(BUSY), 64'(1));
      chk_busy = 1'b0;
    end
    if (DONE) begin
      n_done++;
      done_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: DONE high with no pending op (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("hi", 64'(HI), 64'(e.hi));
        check("lo", 64'(LO), 64'(e.lo));
        check("latency", 64'(cyc - e.cyc), 64'(34));
      end
    end
    if (!RST && START && !BUSY && !DONE) begin
      sb.push_back('{hi: exp_hi, lo: exp_lo, cyc: cyc + 1});
      n_acc++;
      chk_busy = 1'b1;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 120 && n_done < target; i++) tick();
    if (n_done < target) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d DONE pulses expected %0d", n_done, target);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] ehi,
                        input logic [31:0] elo);
    int n0;
    n0 = n_done;
    A = a;
    B = b;
    SIGNED = s;
    exp_hi = ehi;
    exp_lo = elo;
    START = 1'b1;
    tick();
    START = 1'b0;
    A = $urandom;
    B = $urandom;
    SIGNED = 1'($urandom_range(0, 1));
    wait_done(n0 + 1);
    check("done_is_pulse", 64'(DONE), 64'(0));
    check("idle_after_done", 64'(BUSY), 64'(0));
  endtask

  function automatic logic [63:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic s);
    logic signed [63:0] sa, sb2;
    if (s) begin
      sa  = $signed({{32{a[31]}}, a});
      sb2 = $signed({{32{b[31]}}, b});
      return 64'(sa * sb2);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  initial begin
    vec_t        tbl[9];
    logic [63:0] p;
    logic [31:0] ra, rb;
    logic        rs;
    int          n0, a0;

    tbl[0] = '{32'd32, 32'd16, 1'b0, 32'h0, 32'd512};
    tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h1};
    tbl[2] = '{32'hFFFF_FFF0, 32'd32, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FE00};
    tbl[3] = '{32'hFFFF_FFF0, 32'd32, 1'b0, 32'h0000_001F, 32'hFFFF_FE00};
    tbl[4] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0};
    tbl[5] = '{32'h8000_0000, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000};
    tbl[6] = '{32'h0, 32'h1234_5678, 1'b1, 32'h0, 32'h0};
    tbl[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h1};
    tbl[8] = '{32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB};

    repeat (3) tick();
    check("rst_busy", 64'(BUSY), 64'(0));
    check("rst_done", 64'(DONE), 64'(0));
    check("rst_hi", 64'(HI), 64'(0));
    check("rst_lo", 64'(LO), 64'(0));
    RST = 1'b0;
    tick();

    foreach (tbl[i])
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].hi, tbl[i].lo);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'(i & 1);
      p  = model(ra, rb, rs);
      run_op(ra, rb, rs, p[63:32], p[31:0]);
    end

    // START pulsed mid-RUN with other operands must be ignored.
    n0 = n_done;
    A = 32'd32;
    B = 32'd16;
    SIGNED = 1'b0;
    exp_hi = 32'h0;
    exp_lo = 32'd512;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (5) tick();
    A = 32'd7;
    B = 32'd9;
    SIGNED = 1'b1;
    START = 1'b1;
    tick();
    START = 1'b0;
    wait_done(n0 + 1);
    tick();
    check("ignored_start_count", 64'(sb.size()), 64'(0));

    // START held across two operations.
    n0 = n_done;
    a0 = n_acc;
    A = 32'h8000_0001;
    B = 32'd2;
    SIGNED = 1'b0;
    exp_hi = 32'h1;
    exp_lo = 32'h2;
    START = 1'b1;
    tick();
    A = 32'd3;
    B = 32'd5;
    exp_hi = 32'h0;
    exp_lo = 32'd15;
    for (int i = 0; i < 120 && n_acc < a0 + 2; i++) tick();
    START = 1'b0;
    wait_done(n0 + 2);
    if (done_cyc.size() >= 2)
      check("done_spacing", 64'(done_cyc[$] - done_cyc[$-1]), 64'(36));
    tick();

    // Reset in the middle of RUN.
    n0 = n_done;
    A = 32'hFFFF_FFFF;
    B = 32'hFFFF_FFFF;
    SIGNED = 1'b0;
    exp_hi = 32'hFFFF_FFFE;
    exp_lo = 32'h1;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (10) tick();
    RST = 1'b1;
    #1;
    check("midrst_busy", 64'(BUSY), 64'(0));
    check("midrst_done", 64'(DONE), 64'(0));
    check("midrst_hi", 64'(HI), 64'(0));
    check("midrst_lo", 64'(LO), 64'(0));
    sb.delete();
    tick();
    RST = 1'b0;
    tick();
    check("midrst_no_done", 64'(n_done - n0), 64'(0));
    run_op(32'd3, 32'd5, 1'b0, 32'h0, 32'd15);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
